// File: rtl/multiplier_16_bit_seq.sv
// -----------------------------------------------------------------------------
// multiplier_16_bit_seq
//
// Sequential 16x16 unsigned multiplier. A single 4x4 partial-product unit is
// reused for 16 cycles. Each cycle it forms one nibble-by-nibble product. The
// product is shifted into place and added into a 32-bit accumulator.
// Operands are accepted with a valid/ready handshake. The result is handed
// back with a second valid/ready handshake.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous, active-high reset
//   in_valid   : operands a/b are valid
//   in_ready   : block can accept operands (IDLE only)
//   a, b       : 16-bit unsigned operands
//   out_valid  : product is valid (DONE only)
//   out_ready  : consumer accepts the product
//   product    : 32-bit unsigned result
//   busy       : operation in progress or result waiting (RUN or DONE)
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// multiplier_4_bit
//
// Combinational 4x4 unsigned multiplier. The sequential multiplier uses it for
// one partial product per cycle.
//
// Ports
//   a, b     : 4-bit unsigned operands
//   product  : 8-bit unsigned product
// -----------------------------------------------------------------------------
module multiplier_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] product
);

    assign product = {4'b0000, a} * {4'b0000, b};

endmodule

module multiplier_16_bit_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] product,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [31:0] acc;
    logic [3:0]  cnt;

    logic        accept;
    logic        last_step;

    logic [1:0]  i_sel;
    logic [1:0]  j_sel;
    logic [3:0]  a_nib;
    logic [3:0]  b_nib;
    logic [7:0]  pp;
    logic [4:0]  shift_amt;
    logic [31:0] pp_shifted;

    // The low counter bits step through the nibbles of A. The high bits step
    // through the nibbles of B. Every (i, j) pair is visited exactly once in
    // 16 cycles.
    assign i_sel = cnt[1:0];
    assign j_sel = cnt[3:2];

    assign a_nib = a_reg[{i_sel, 2'b00} +: 4];
    assign b_nib = b_reg[{j_sel, 2'b00} +: 4];

    multiplier_4_bit u_mul4 (
        .a       (a_nib),
        .b       (b_nib),
        .product (pp)
    );

    // The weight of nibble pair (i, j) is 16^(i+j), which is a shift of
    // 4*(i+j), in the range 0..24. The sum i+j needs 3 bits to hold 6.
    assign shift_amt  = {({1'b0, i_sel} + {1'b0, j_sel}), 2'b00};
    assign pp_shifted = {24'b0, pp} << shift_amt;

    assign last_step = (cnt == 4'd15);

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The accumulator is not cleared when the result handshake completes.
    // The last result therefore stays visible on product while the block is
    // IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == RUN) begin
            // The counter wraps from 15 to 0 on the final add.
            acc <= acc + pp_shifted;
            cnt <= cnt + 4'd1;
        end
    end

    assign product = acc;

endmodule

// File: tb/tb_multiplier_16_bit_seq.sv
module tb_multiplier_16_bit_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;

    multiplier_16_bit_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t        vecs [0:7];

    int          errors;
    int          checks;
    int          cyc;
    int          last_acc;
    bit          rand_stall;
    logic        samp_rdy;
    logic        samp_ov;
    logic        ov_prev;
    logic [31:0] exp_q [$];
    int          acc_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard side, sampled at the falling edge.
    task automatic sample();
        samp_rdy = in_ready;
        samp_ov  = out_valid;
        if (rst) begin
            ov_prev = 1'b0;
            return;
        end
        chk("ready_vs_busy", {31'b0, in_ready}, {31'b0, ~busy});
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL unexpected_out_valid: got product %h, expected no output", product);
            end else begin
                chk("product", product, exp_q[0]);
                if (!ov_prev) begin
                    chk("latency", cyc - acc_q[0], 32'd16);
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                end
            end
        end
        ov_prev = out_valid;
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        if (rand_stall) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic [31:0] ev);
        bit done;
        done     = 1'b0;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            step();
            if (samp_rdy) begin
                done = 1'b1;
                exp_q.push_back(ev);
                acc_q.push_back(cyc);
                last_acc = cyc;
            end
        end
        in_valid = 1'b0;
        checks = checks + 1;
        if (!done) begin
            errors = errors + 1;
            $display("FAIL accept_timeout: got no accept, expected accept of a=%h b=%h", av, bv);
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            step();
            if (exp_q.size() == 0 && samp_rdy) done = 1'b1;
        end
        checks = checks + 1;
        if (!done) begin
            errors = errors + 1;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
        end
    endtask

    task automatic wait_out_valid();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            step();
            if (samp_ov) done = 1'b1;
        end
        checks = checks + 1;
        if (!done) begin
            errors = errors + 1;
            $display("FAIL out_valid_timeout: got out_valid=0, expected 1");
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t1;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [31:0] re;

        errors     = 0;
        checks     = 0;
        cyc        = 0;
        last_acc   = 0;
        rand_stall = 1'b0;
        ov_prev    = 1'b0;
        samp_rdy   = 1'b0;
        samp_ov    = 1'b0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        out_ready  = 1'b0;

        vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2] = '{16'h8000, 16'h8000, 32'h40000000};
        vecs[3] = '{16'h0000, 16'hFFFF, 32'h00000000};
        vecs[4] = '{16'hFFFF, 16'h0001, 32'h0000FFFF};
        vecs[5] = '{16'h00FF, 16'h0101, 32'h0000FFFF};
        vecs[6] = '{16'h1234, 16'h5678, 32'h06260060};
        vecs[7] = '{16'hF000, 16'h0F00, 32'h0E100000};

        // Reset state
        step();
        step();
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy",      {31'b0, busy},      32'd0);
        chk("rst_product",   product,            32'd0);
        rst = 1'b0;
        step();

        // Basic product with handshake timing
        out_ready = 1'b1;
        send(16'h0003, 16'h0005, 32'h0000000F);
        wait_out_valid();
        chk("basic_ready_in_done", {31'b0, samp_rdy}, 32'd0);
        step();
        chk("basic_ready_after", {31'b0, samp_rdy}, 32'd1);
        chk("basic_ov_after",    {31'b0, samp_ov},  32'd0);
        drain();

        // Vector table
        for (int v = 0; v < 8; v++) begin
            send(vecs[v].a, vecs[v].b, vecs[v].p);
            drain();
        end

        // Output backpressure
        out_ready = 1'b0;
        send(16'h1234, 16'h5678, 32'h06260060);
        wait_out_valid();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_hold_ov", {31'b0, samp_ov}, 32'd1);
        end
        out_ready = 1'b1;
        step();
        chk("bp_idle_ready", {31'b0, in_ready},  32'd1);
        chk("bp_idle_ov",    {31'b0, out_valid}, 32'd0);
        chk("bp_keep_prod",  product,            32'h06260060);
        drain();

        // Reset mid-operation
        send(16'hABCD, 16'h1111, 32'hABCD * 32'h1111);
        for (int k = 0; k < 8; k++) step();
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_product",   product,            32'd0);
        chk("mrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mrst_busy",      {31'b0, busy},      32'd0);
        chk("mrst_in_ready",  {31'b0, in_ready},  32'd1);
        exp_q.delete();
        acc_q.delete();
        step();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) step();
        send(16'h0002, 16'h0007, 32'h0000000E);
        drain();

        // Inputs ignored while busy, back-to-back issue
        send(16'h00FF, 16'h0101, 32'h0000FFFF);
        t1 = last_acc;
        send(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        chk("busy_ignore_interval", last_acc - t1, 32'd18);
        drain();

        // Random regression with output stalls
        rand_stall = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            ra = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            re = {16'b0, ra} * {16'b0, rb};
            send(ra, rb, re);
        end
        drain();
        rand_stall = 1'b0;
        out_ready  = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
